// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Provides the FSM state type, depth derivation and Gray-to-binary conversion.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int depth_of(input int ptr_size);
        return 1 << ptr_size;
    endfunction

    // Works for any pointer width up to 32 as long as the unused upper bits are zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake and FIFO write-port bundle shared by the arbiter and its environment.
// Handshake: a requester beat transfers on a rising edge where req_valid[i] & req_ready[i] are both 1;
// req_data must be stable while req_valid is high, and req_ready never depends on anything but grant state and full.
interface fifo_wr_arbiter_if #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int PTR_SIZE = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               full;
    logic [PTR_SIZE:0]  b_wptr;
    logic [PTR_SIZE:0]  g_rptr_sync;
    logic               w_en;
    logic [DW-1:0]      wdata;

    modport master (
        output req_valid, req_data, full, b_wptr, g_rptr_sync,
        input  req_ready, w_en, wdata
    );

    modport slave (
        input  req_valid, req_data, full, b_wptr, g_rptr_sync,
        output req_ready, w_en, wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward from last_owner+1.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_owner,
    output logic [$clog2(NREQ)-1:0] grant,
    output logic                    any
);
    localparam int OW = $clog2(NREQ);

    logic [OW-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = OW'((int'(last_owner) + k) % NREQ);
            if (req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port; bursts are admitted only
// when free space covers a full burst. Also reports registered fill level and almost-full.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int PTR_SIZE  = 8,
    parameter int MAX_BURST = 4,
    parameter int AF_MARGIN = 16
) (
    input  logic                    w_clk,
    input  logic                    wrst_n,
    fifo_wr_arbiter_if.slave        bus,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic [PTR_SIZE:0]       fill_level,
    output logic                    almost_full
);
    localparam int OW    = $clog2(NREQ);
    localparam int CW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int DEPTH = depth_of(PTR_SIZE);

    localparam logic [PTR_SIZE:0] DEPTH_W   = (PTR_SIZE+1)'(DEPTH);
    localparam logic [PTR_SIZE:0] BURST_W   = (PTR_SIZE+1)'(MAX_BURST);
    localparam logic [PTR_SIZE:0] MARGIN_W  = (PTR_SIZE+1)'(AF_MARGIN);
    localparam logic [CW-1:0]     LAST_BEAT = CW'(MAX_BURST - 1);

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [CW-1:0] beat_q, beat_d;

    logic [PTR_SIZE:0] rptr_bin;
    logic [PTR_SIZE:0] occ;
    logic [PTR_SIZE:0] free;
    logic              room;
    logic [OW-1:0]     pick;
    logic              pick_any;
    logic              own_valid;
    logic [DW-1:0]     own_data;
    logic              xfer;

    // Modulo subtraction handles pointer wrap; occ == DEPTH when only the MSBs differ.
    assign rptr_bin = (PTR_SIZE+1)'(gray2bin(32'(bus.g_rptr_sync)));
    assign occ      = bus.b_wptr - rptr_bin;
    assign free     = DEPTH_W - occ;
    assign room     = (free >= BURST_W);

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (bus.req_valid),
        .last_owner (last_q),
        .grant      (pick),
        .any        (pick_any)
    );

    assign own_valid = bus.req_valid[owner_q];
    assign own_data  = bus.req_data[int'(owner_q)*DW +: DW];

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        beat_d        = beat_q;
        bus.req_ready = '0;
        bus.w_en      = 1'b0;
        bus.wdata     = '0;
        xfer          = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any && room) begin
                    state_d = GRANT;
                    owner_d = pick;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                bus.req_ready[owner_q] = ~bus.full;
                xfer                   = own_valid & ~bus.full;
                bus.w_en               = xfer;
                if (xfer) begin
                    bus.wdata = own_data;
                    beat_d    = beat_q + 1'b1;
                end
                // A full stall with valid held keeps the grant; only completion or a dropped valid releases.
                if ((xfer && beat_q == LAST_BEAT) || !own_valid) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= OW'(NREQ - 1);
            beat_q      <= '0;
            fill_level  <= '0;
            almost_full <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            fill_level  <= occ;
            almost_full <= (free <= MARGIN_W);
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with hand-computed expectations.
module tb_fifo_wr_arbiter;
    logic       w_clk;
    logic       wrst_n;
    logic [1:0] owner;
    logic       busy;
    logic [8:0] fill_level;
    logic       almost_full;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter_if #(.NREQ(4), .DW(8), .PTR_SIZE(8)) bus ();

    fifo_wr_arbiter #(
        .NREQ(4), .DW(8), .PTR_SIZE(8), .MAX_BURST(4), .AF_MARGIN(16)
    ) dut (
        .w_clk       (w_clk),
        .wrst_n      (wrst_n),
        .bus         (bus),
        .owner       (owner),
        .busy        (busy),
        .fill_level  (fill_level),
        .almost_full (almost_full)
    );

    // clock / reset
    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs at the falling edge, then advance to just after the rising edge.
    task automatic step(input logic eb, input logic ew, input logic [7:0] ed,
                        input logic [1:0] eo, input logic [3:0] er, input string tag);
        @(negedge w_clk);
        chk({tag, " busy"},      32'(busy),          32'(eb));
        chk({tag, " w_en"},      32'(bus.w_en),      32'(ew));
        chk({tag, " wdata"},     32'(bus.wdata),     32'(ed));
        chk({tag, " owner"},     32'(owner),         32'(eo));
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(er));
        @(posedge w_clk);
        #1;
    endtask

    task automatic check_stat(input logic [8:0] ef, input logic ea, input string tag);
        chk({tag, " fill_level"},  32'(fill_level),  32'(ef));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(ea));
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        bus.req_data[i*8 +: 8] = d;
    endtask

    initial begin
        wrst_n          = 1'b0;
        bus.req_valid   = 4'b0000;
        bus.req_data    = '0;
        bus.full        = 1'b0;
        bus.b_wptr      = 9'h000;
        bus.g_rptr_sync = 9'h000;

        // reset state
        @(negedge w_clk);
        chk("rst busy",        32'(busy),          32'd0);
        chk("rst owner",       32'(owner),         32'd0);
        chk("rst fill",        32'(fill_level),    32'd0);
        chk("rst almost_full", 32'(almost_full),   32'd0);
        chk("rst w_en",        32'(bus.w_en),      32'd0);
        chk("rst wdata",       32'(bus.wdata),     32'd0);
        chk("rst req_ready",   32'(bus.req_ready), 32'd0);
        @(posedge w_clk);
        #1;
        wrst_n = 1'b1;

        // single requester: two back-to-back bursts with one idle gap
        bus.req_valid = 4'b0001;
        set_data(0, 8'h10);
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t1 arb");
        for (int b = 0; b < 4; b++) begin
            step(1'b1, 1'b1, 8'(8'h10 + b), 2'd0, 4'b0001, "t1 burst0");
            set_data(0, 8'(8'h11 + b));
        end
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t1 gap");
        for (int b = 0; b < 4; b++) begin
            step(1'b1, 1'b1, 8'(8'h14 + b), 2'd0, 4'b0001, "t1 burst1");
            set_data(0, 8'(8'h15 + b));
        end
        bus.req_valid = 4'b0000;
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t1 idle");

        // owner 2 drops valid after two beats; next grant searches from 3
        bus.req_valid = 4'b0100;
        set_data(2, 8'hC2);
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t2 arb");
        step(1'b1, 1'b1, 8'hC2, 2'd2, 4'b0100, "t2 beat1");
        step(1'b1, 1'b1, 8'hC2, 2'd2, 4'b0100, "t2 beat2");
        bus.req_valid = 4'b1001;
        set_data(0, 8'h30);
        set_data(3, 8'hD3);
        step(1'b1, 1'b0, 8'h00, 2'd2, 4'b0100, "t2 drop");
        step(1'b0, 1'b0, 8'h00, 2'd2, 4'b0000, "t2 rearb");
        step(1'b1, 1'b1, 8'hD3, 2'd3, 4'b1000, "t2 owner3");
        bus.req_valid = 4'b0000;
        step(1'b1, 1'b0, 8'h00, 2'd3, 4'b1000, "t2 release");
        step(1'b0, 1'b0, 8'h00, 2'd3, 4'b0000, "t2 idle");

        // admission stall: occ=253, free=3
        bus.b_wptr      = 9'h0FD;
        bus.g_rptr_sync = 9'h000;
        bus.req_valid   = 4'b0001;
        set_data(0, 8'h40);
        step(1'b0, 1'b0, 8'h00, 2'd3, 4'b0000, "t3 stall0");
        check_stat(9'd253, 1'b1, "t3 occ253");
        step(1'b0, 1'b0, 8'h00, 2'd3, 4'b0000, "t3 stall1");
        bus.g_rptr_sync = 9'h001;
        step(1'b0, 1'b0, 8'h00, 2'd3, 4'b0000, "t3 admit");
        check_stat(9'd252, 1'b1, "t3 occ252");
        step(1'b1, 1'b1, 8'h40, 2'd0, 4'b0001, "t3 beat");
        bus.req_valid = 4'b0000;
        step(1'b1, 1'b0, 8'h00, 2'd0, 4'b0001, "t3 release");
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t3 idle");

        // pointer wrap: 0x105 - 0xFE = 7 ; gray(0xFE) = 0x81
        bus.b_wptr      = 9'h105;
        bus.g_rptr_sync = 9'h081;
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t4 wrap");
        check_stat(9'd7, 1'b0, "t4 wrap");
        // completely full: MSBs differ, rest equal -> occ = DEPTH, no admission
        bus.b_wptr      = 9'h100;
        bus.g_rptr_sync = 9'h000;
        bus.req_valid   = 4'b0001;
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t4 full0");
        check_stat(9'd256, 1'b1, "t4 occ256");
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t4 full1");

        // full flag while granted: hold grant, no write, no ready
        bus.b_wptr = 9'h000;
        bus.full   = 1'b1;
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t5 arb");
        check_stat(9'd0, 1'b0, "t5 empty");
        step(1'b1, 1'b0, 8'h00, 2'd0, 4'b0000, "t5 hold0");
        step(1'b1, 1'b0, 8'h00, 2'd0, 4'b0000, "t5 hold1");
        bus.full = 1'b0;
        step(1'b1, 1'b1, 8'h40, 2'd0, 4'b0001, "t5 beat");
        bus.req_valid = 4'b0000;
        step(1'b1, 1'b0, 8'h00, 2'd0, 4'b0001, "t5 release");
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t5 idle");

        // reset during beat 2 of a burst owned by requester 1
        bus.b_wptr    = 9'h005;
        bus.req_valid = 4'b0010;
        set_data(1, 8'h55);
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t6 arb");
        step(1'b1, 1'b1, 8'h55, 2'd1, 4'b0010, "t6 beat1");
        @(negedge w_clk);
        chk("t6 beat2 w_en", 32'(bus.w_en), 32'd1);
        chk("t6 pre fill",   32'(fill_level), 32'd5);
        #1;
        wrst_n = 1'b0;
        #1;
        chk("t6 rst busy",      32'(busy),          32'd0);
        chk("t6 rst w_en",      32'(bus.w_en),      32'd0);
        chk("t6 rst wdata",     32'(bus.wdata),     32'd0);
        chk("t6 rst req_ready", 32'(bus.req_ready), 32'd0);
        chk("t6 rst owner",     32'(owner),         32'd0);
        chk("t6 rst fill",      32'(fill_level),    32'd0);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'hA0 + i));
        @(posedge w_clk);
        #1;
        wrst_n = 1'b1;

        // all four valid: owners 0,1,2,3,0, four beats each, one gap between
        step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, "t7 arb");
        for (int n = 0; n < 5; n++) begin
            for (int b = 0; b < 4; b++) begin
                step(1'b1, 1'b1, 8'(8'hA0 + (n % 4)), 2'(n % 4), 4'(1 << (n % 4)), "t7 beat");
            end
            step(1'b0, 1'b0, 8'h00, 2'(n % 4), 4'b0000, "t7 gap");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
